sqrt_iter_ctrl: RTL and testbench

Iterative integer square-root sequencer. It computes floor(sqrt(X)) and the remainder for a 2N-bit radicand, producing one root bit per cycle with the restoring digit-by-digit algorithm. The block contains no adder of its own: it drives one external combinational CLA adder (width N+3), configured as a subtractor, and owns that adder exclusively. It is the multicycle, low-area counterpart of the pipelined square-root datapath and uses valid/ready handshakes on both sides.

---
 rtl/sqrt_iter_ctrl.sv | 124 ++++++++++++
 tb/tb_sqrt_iter_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_iter_ctrl.sv
// rtl/sqrt_iter_ctrl.sv - iterative restoring integer square root, one root bit per cycle
// Uses an external CLA adder (ADD_W = N+3) as a subtractor; valid/ready on both sides.
module sqrt_iter_ctrl #(
  parameter int N = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2*N-1:0]   radicand_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [N-1:0]     root_o,
  output logic [N:0]       rem_o,
  output logic [N+2:0]     add_a_o,
  output logic [N+2:0]     add_b_o,
  output logic             add_ci_o,
  input  logic [N+2:0]     add_s_i,
  input  logic             add_co_i
);

  localparam int ADD_W = N + 3;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   xsh_q, xsh_d;
  logic [N:0]       r_q, r_d;
  logic [N-1:0]     q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ADD_W-1:0] trial;
  logic [ADD_W-1:0] sub;

  // Trial remainder brings down the next two radicand bits; subtrahend is 4Q+1.
  assign trial = {r_q, xsh_q[2*N-1 -: 2]};
  assign sub   = {1'b0, q_q, 2'b01};

  // Upper sum/trial bits are zero by the R <= 2Q invariant whenever they are kept.
  logic unused_hi;
  assign unused_hi = ^{add_s_i[ADD_W-1:N+1], trial[ADD_W-1:N+1]};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      xsh_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      xsh_q   <= xsh_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    xsh_d       = xsh_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    add_a_o     = '0;
    add_b_o     = '0;
    add_ci_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          xsh_d   = radicand_i;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = CNT_W'(N - 1);
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        add_a_o  = trial;
        add_b_o  = ~sub;
        add_ci_o = 1'b1;
        // Carry-out set means no borrow: the trial subtraction is kept.
        if (add_co_i) begin
          r_d = add_s_i[N:0];
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          r_d = trial[N:0];
          q_d = {q_q[N-2:0], 1'b0};
        end
        xsh_d = xsh_q << 2;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign root_o = q_q;
  assign rem_o  = r_q;

endmodule

// File: tb/tb_sqrt_iter_ctrl.sv
// tb/tb_sqrt_iter_ctrl.sv - self-checking bench for sqrt_iter_ctrl with a behavioural adder
module tb_sqrt_iter_ctrl;

  localparam int N     = 8;
  localparam int ADD_W = N + 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   radicand;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     root;
  logic [N:0]       rem;
  logic [ADD_W-1:0] add_a;
  logic [ADD_W-1:0] add_b;
  logic             add_ci;
  logic [ADD_W-1:0] add_s;
  logic             add_co;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int x;
    int root;
    int rem;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{ADD_W{1'b0}}, add_ci};

  sqrt_iter_ctrl #(.N(N)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .radicand_i  (radicand),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .root_o      (root),
    .rem_o       (rem),
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_ci_o    (add_ci),
    .add_s_i     (add_s),
    .add_co_i    (add_co)
  );

  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic push_exp(input int x);
    exp_t e;
    e.x    = x;
    e.root = isqrt(x);
    e.rem  = x - e.root * e.root;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic start_op(input int x, output int acc_edge, output bit ok);
    int w;
    w        = 0;
    in_valid = 1'b1;
    radicand = 16'(x);
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    ok       = in_ready;
    acc_edge = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    if (ok) push_exp(x);
  endtask

  task automatic wait_done(output int done_edge, output bit ok);
    int w;
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    ok        = out_valid;
    done_edge = cyc;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    radicand  = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_hs: in_ready/out_valid=%b expected 10", {in_ready, out_valid});
    end
    vectors++;
    if (root !== '0 || rem !== '0 || add_a !== '0 || add_b !== '0 || add_ci !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data: root=%0d rem=%0d a=%h b=%h ci=%b expected all 0",
               root, rem, add_a, add_b, add_ci);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_144();
    int acc, done_e, w;
    bit ok, bad_ready;
    exp_t e;
    out_ready = 1'b0;
    start_op(144, acc, ok);
    bad_ready = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      if (in_ready) bad_ready = 1'b1;
      @(negedge clk);
      w++;
    end
    done_e = cyc;
    vectors++;
    if (!ok || !out_valid) begin
      miscompares++;
      $display("FAIL basic_handshake: accepted=%b out_valid=%b expected 1 1", ok, out_valid);
    end
    vectors++;
    if (bad_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ready_iter: in_ready seen=%b during ITER expected 0", bad_ready);
    end
    vectors++;
    if (done_e - acc != N) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d expected %0d", done_e - acc, N);
    end
    e = sb.pop_front();
    vectors++;
    if (int'(root) != e.root || int'(rem) != e.rem || root !== 8'd12 || rem !== 9'd0) begin
      miscompares++;
      $display("FAIL basic_144: root=%0d rem=%0d expected root=%0d rem=%0d", root, rem, e.root, e.rem);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int xs[4];
    int acc, prev_acc, done_e;
    bit ok, ok2;
    exp_t e;
    xs = '{0, 65535, 200, 16383};
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int i = 0; i < 4; i++) begin
      start_op(xs[i], acc, ok);
      if (i > 0) begin
        vectors++;
        if (acc - prev_acc != N + 2) begin
          miscompares++;
          $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, acc - prev_acc, N + 2);
        end
      end
      prev_acc = acc;
      wait_done(done_e, ok2);
      vectors++;
      if (!ok || !ok2 || done_e - acc != N) begin
        miscompares++;
        $display("FAIL b2b_latency[%0d]: acc=%b done=%b lat=%0d expected %0d", i, ok, ok2, done_e - acc, N);
      end
      if (ok) begin
        e = sb.pop_front();
        vectors++;
        if (int'(root) != e.root || int'(rem) != e.rem) begin
          miscompares++;
          $display("FAIL b2b_result[%0d]: root=%0d rem=%0d expected root=%0d rem=%0d",
                   i, root, rem, e.root, e.rem);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int acc, done_e;
    bit ok, ok2, seen_valid;
    exp_t e;
    out_ready = 1'b0;
    start_op(65535, acc, ok);
    wait_done(done_e, ok2);
    e = sb.pop_front();
    for (int k = 0; k < 20; k++) begin
      vectors++;
      if (!out_valid || in_ready || int'(root) != e.root || int'(rem) != e.rem) begin
        miscompares++;
        $display("FAIL hold[%0d]: valid=%b ready=%b root=%0d rem=%0d expected 1 0 %0d %0d",
                 k, out_valid, in_ready, root, rem, e.root, e.rem);
      end
      in_valid = (k % 3 == 0);
      radicand = 16'd123;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL hold_release: valid/ready=%b expected 01", {out_valid, in_ready});
    end
    seen_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    vectors++;
    if (seen_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_ignored_input: spurious out_valid=%b expected 0", seen_valid);
    end
  endtask

  task automatic test_reset_abort();
    int acc, done_e;
    bit ok, ok2;
    exp_t e;
    out_ready = 1'b1;
    start_op(1000, acc, ok);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if (ok) void'(sb.pop_back());
    vectors++;
    if ({in_ready, out_valid} !== 2'b10 || add_a !== '0 || add_b !== '0 || add_ci !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: ready=%b valid=%b a=%h b=%h ci=%b expected 1 0 0 0 0",
               in_ready, out_valid, add_a, add_b, add_ci);
    end
    start_op(1000, acc, ok);
    wait_done(done_e, ok2);
    e = sb.pop_front();
    vectors++;
    if (!ok2 || int'(root) != e.root || int'(rem) != e.rem || root !== 8'd31 || rem !== 9'd39) begin
      miscompares++;
      $display("FAIL abort_rerun: root=%0d rem=%0d expected root=31 rem=39", root, rem);
    end
    @(negedge clk);
  endtask

  task automatic test_adder_drive();
    int acc, done_e;
    bit ok, ok2;
    logic [ADD_W-1:0] exp_b;
    exp_t e;
    exp_b     = ~(ADD_W'(1));
    out_ready = 1'b1;
    start_op(16'hC000, acc, ok);
    vectors++;
    if (add_a !== ADD_W'(3) || add_b !== exp_b || add_ci !== 1'b1) begin
      miscompares++;
      $display("FAIL adder_drive: a=%h b=%h ci=%b expected a=%h b=%h ci=1", add_a, add_b, add_ci,
               ADD_W'(3), exp_b);
    end
    @(negedge clk);
    vectors++;
    if (root !== 8'd1) begin
      miscompares++;
      $display("FAIL adder_first_bit: Q=%0d expected 1", root);
    end
    wait_done(done_e, ok2);
    e = sb.pop_front();
    vectors++;
    if (!ok2 || int'(root) != e.root || int'(rem) != e.rem || add_a !== '0 || add_ci !== 1'b0) begin
      miscompares++;
      $display("FAIL adder_result: root=%0d rem=%0d a=%h ci=%b expected root=%0d rem=%0d a=0 ci=0",
               root, rem, add_a, add_ci, e.root, e.rem);
    end
    @(negedge clk);
  endtask

  task automatic run_sweep_one(input int x);
    int acc, done_e, r;
    bit ok, ok2;
    exp_t e;
    start_op(x, acc, ok);
    wait_done(done_e, ok2);
    vectors++;
    if (!ok || !ok2) begin
      miscompares++;
      $display("FAIL sweep_timeout x=%0d: accepted=%b done=%b expected 1 1", x, ok, ok2);
      return;
    end
    e = sb.pop_front();
    r = int'(root);
    if (r * r > x || (r + 1) * (r + 1) <= x || int'(rem) != x - r * r || r != e.root) begin
      miscompares++;
      $display("FAIL sweep x=%0d: root=%0d rem=%0d expected root=%0d rem=%0d", x, root, rem, e.root, e.rem);
    end
  endtask

  task automatic test_sweep();
    int x;
    out_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      for (int d = -1; d <= 1; d++) begin
        x = k * k + d;
        if (x >= 0 && x <= 65535) run_sweep_one(x);
      end
    end
    run_sweep_one(65535);
    for (int i = 0; i < 200; i++) run_sweep_one(int'($urandom_range(65535, 0)));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_144();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    test_adder_drive();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
